bcd_seq_checker: RTL
====================

Name: bcd_seq_checker

Overview:
- Receive-side monitor for the 4-bit output of a synchronous mod-10 counter.
- Samples the BCD count stream and checks every sample is the previous value +1 mod 10 (9 -> 0 wrap).
- Reports lock status, sequence errors, illegal codes (>9) and completed decades.
- Sits downstream of the counter; its outputs feed status logic and self-checking benches.

Parameters:
LOCK_COUNT, 3, consecutive correct increments required to enter LOCKED (legal range 1..15)
ERR_CNT_W, 8, width of err_count
WRAP_CNT_W, 8, width of wrap_count

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset; reset=0 at a rising clk edge resets the block
q_in  input  4  BCD count value from the upstream counter
q_valid  input  1  q_in is sampled only on edges where q_valid=1
locked  output  1  1 while FSM is in LOCKED
err_pulse  output  1  one-cycle pulse, sequence mismatch while LOCKED
illegal  output  1  one-cycle pulse, a sampled q_in > 9
err_count  output  ERR_CNT_W  saturating count of err_pulse events
wrap_count  output  WRAP_CNT_W  count of 9->0 transitions seen while LOCKED; wraps modulo 2^WRAP_CNT_W
exp_q  output  4  next expected value, i.e. (prev+1) mod 10; 0 when no prev is held

Behaviour:
- All state is on posedge clk. reset=0 forces: FSM=HUNT, prev=0, good=0, and all outputs 0. Reset has priority over q_valid.
- Reset mid-stream discards lock and history; counters clear.
- Outputs are registered. A response to the sample taken at edge N is visible after edge N, for exactly one cycle for pulses.
- Edges with q_valid=0 change nothing; pulses drop to 0.
- next(v) = v+1 if v<9, 0 if v=9.
- Illegal sample (q_in 10..15, q_valid=1), from any state:
  - illegal=1
  - FSM -> HUNT, good=0, exp_q=0
  - in LOCKED it also counts as a mismatch: err_pulse=1 and err_count increments.
- HUNT, legal sample: prev=q_in, good=0, FSM -> ACQUIRE.
- ACQUIRE, legal sample:
  - match (q_in==next(prev)): good++; if good reaches LOCK_COUNT -> LOCKED, locked=1 after that edge.
  - mismatch: good=0, stay in ACQUIRE.
  - prev=q_in in both cases.
  - No err_pulse in ACQUIRE.
- LOCKED, legal sample:
  - match: stay; if prev=9 and q_in=0, wrap_count++.
  - mismatch: err_pulse=1, err_count++ (holds at all-ones), FSM -> ACQUIRE, good=0, prev=q_in.
- Repeated value (q_in==prev) is a mismatch.
- exp_q always reflects next(prev) whenever FSM is not HUNT.
- err_count saturates. wrap_count rolls over with no flag.

Optional Feature:
- Macro: BCD_CHK_ZERO_RESYNC_EN.
- Defined: in LOCKED, a legal sample of 0 that mismatches is treated as an upstream counter reset:
  - no err_pulse, err_count unchanged, wrap_count unchanged
  - prev=0, FSM stays LOCKED.
- Not defined: that case is an ordinary mismatch, as described above.
- Illegal-code handling is identical either way.

Test Plan:
- Hold reset=0 for 3 edges with q_in=7, q_valid=1 -> all outputs 0, FSM in HUNT; release, then q_in=7 -> exp_q=8, locked=0.
- Feed 0,1,2,3 with LOCK_COUNT=3 -> locked=1 after the 4th sample; continue 4..9,0,1 -> wrap_count=1, err_count=0.
- Locked at 5, feed 7 -> err_pulse=1 for one cycle, err_count=1, locked=0; then 8,9,0 -> locked=1 again, no further errors.
- Locked, feed q_in=12 -> illegal=1 and err_pulse=1 one cycle, locked=0, exp_q=0; then 3 -> exp_q=4, FSM in ACQUIRE.
- Locked at 4, feed 0: without macro -> err_pulse=1, err_count+1, locked=0; with BCD_CHK_ZERO_RESYNC_EN -> no pulse, locked stays 1, then 1 is accepted.
- Toggle q_valid=0 between samples 2 and 3 for 5 cycles with q_in=15 -> no illegal pulse, sequence continues. Force 300 errors with ERR_CNT_W=8 -> err_count holds at 255.

Source files
------------

// File: rtl/bcd_seq_checker.sv
// Receive-side monitor for a mod-10 counter: checks that each valid sample is the previous +1 mod 10.
// Optional BCD_CHK_ZERO_RESYNC_EN: in LOCKED, a mismatching 0 is taken as an upstream counter reset.
module bcd_seq_checker #(
   parameter int unsigned LOCK_COUNT = 3,
   parameter int unsigned ERR_CNT_W  = 8,
   parameter int unsigned WRAP_CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            q_in,
   input  logic                  q_valid,
   output logic                  locked,
   output logic                  err_pulse,
   output logic                  illegal,
   output logic [ERR_CNT_W-1:0]  err_count,
   output logic [WRAP_CNT_W-1:0] wrap_count,
   output logic [3:0]            exp_q
);

   // state   | meaning
   // HUNT    | no previous sample held; next legal sample seeds prev
   // ACQUIRE | counting consecutive correct increments toward LOCK_COUNT
   // LOCKED  | in sequence; mismatches are reported as errors
   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   localparam logic [3:0] LOCK_CNT_L = 4'(LOCK_COUNT);

   state_t                state_q;
   logic [3:0]            prev_q;
   logic [3:0]            good_q;
   logic                  locked_q;
   logic                  err_pulse_q;
   logic                  illegal_q;
   logic [ERR_CNT_W-1:0]  err_count_q;
   logic [WRAP_CNT_W-1:0] wrap_count_q;
   logic [3:0]            exp_q_q;

   function automatic logic [3:0] bcd_next(input logic [3:0] v);
      return (v == 4'd9) ? 4'd0 : v + 4'd1;
   endfunction

   logic                 sample_illegal;
   logic                 sample_match;
   logic [3:0]           good_inc;
   logic [ERR_CNT_W-1:0] err_count_d;

   assign sample_illegal = (q_in > 4'd9);
   assign sample_match   = (q_in == bcd_next(prev_q));
   assign good_inc       = good_q + 4'd1;
   assign err_count_d    = (&err_count_q) ? err_count_q : err_count_q + ERR_CNT_W'(1);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= HUNT;
         prev_q       <= 4'd0;
         good_q       <= 4'd0;
         locked_q     <= 1'b0;
         err_pulse_q  <= 1'b0;
         illegal_q    <= 1'b0;
         err_count_q  <= '0;
         wrap_count_q <= '0;
         exp_q_q      <= 4'd0;
      end else begin
         err_pulse_q <= 1'b0;
         illegal_q   <= 1'b0;
         if (q_valid) begin
            if (sample_illegal) begin
               illegal_q <= 1'b1;
               state_q   <= HUNT;
               good_q    <= 4'd0;
               prev_q    <= 4'd0;
               exp_q_q   <= 4'd0;
               locked_q  <= 1'b0;
               if (state_q == LOCKED) begin
                  err_pulse_q <= 1'b1;
                  err_count_q <= err_count_d;
               end
            end else begin
               prev_q  <= q_in;
               exp_q_q <= bcd_next(q_in);
               case (state_q)
                  HUNT: begin
                     good_q  <= 4'd0;
                     state_q <= ACQUIRE;
                  end
                  ACQUIRE: begin
                     if (sample_match) begin
                        good_q <= good_inc;
                        if (good_inc == LOCK_CNT_L) begin
                           state_q  <= LOCKED;
                           locked_q <= 1'b1;
                        end
                     end else begin
                        good_q <= 4'd0;
                     end
                  end
                  LOCKED: begin
                     if (sample_match) begin
                        if (q_in == 4'd0) begin
                           wrap_count_q <= wrap_count_q + WRAP_CNT_W'(1);
                        end
`ifdef BCD_CHK_ZERO_RESYNC_EN
                     end else if (q_in == 4'd0) begin
                        state_q <= LOCKED;
`endif
                     end else begin
                        err_pulse_q <= 1'b1;
                        err_count_q <= err_count_d;
                        state_q     <= ACQUIRE;
                        good_q      <= 4'd0;
                        locked_q    <= 1'b0;
                     end
                  end
                  default: begin
                     state_q  <= HUNT;
                     good_q   <= 4'd0;
                     locked_q <= 1'b0;
                     exp_q_q  <= 4'd0;
                  end
               endcase
            end
         end
      end
   end

   assign locked     = locked_q;
   assign err_pulse  = err_pulse_q;
   assign illegal    = illegal_q;
   assign err_count  = err_count_q;
   assign wrap_count = wrap_count_q;
   assign exp_q      = exp_q_q;

endmodule
